// File: rtl/uart_tx.sv
// UART transmitter: one start bit, MSG_BITS data bits LSB first, one stop bit, no parity.
// A ready/valid-style request starts a frame; done_o pulses once the stop bit has completed.
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int MSG_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MSG_BITS-1:0] symbol_i,
  input  logic                send_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                uart_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(MSG_BITS);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (MSG_BITS < 5 || MSG_BITS > 9) begin : g_bad_width
      $error("uart_tx: MSG_BITS must be in 5..9");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [MSG_BITS-1:0] shift_q, shift_d;
  logic                uart_q, uart_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                baud_last;

  assign baud_last = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    uart_d  = uart_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_i && ready_q) begin
          state_d = START;
          shift_d = symbol_i;
          baud_d  = '0;
          uart_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          baud_d  = '0;
          idx_d   = '0;
          uart_d  = shift_q[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == IDX_W'(MSG_BITS - 1)) begin
            state_d = STOP;
            uart_d  = 1'b1;
          end else begin
            // Bit 1 of the current shift value is the next bit to drive.
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            uart_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          state_d = IDLE;
          baud_d  = '0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        uart_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      uart_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      uart_q  <= uart_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign uart_o  = uart_q;
  assign ready_o = ready_q;
  assign done_o  = done_q;

endmodule
